// File: rtl/ws_pe_dbuf.sv
// ws_pe_dbuf: weight-stationary systolic processing element with a double-buffered weight.
//
// Each PE multiplies the activation arriving from the left by its active weight. It adds the
// product to the partial sum arriving from above. The activation goes on to the right and the
// new partial sum goes down, both registered with one cycle of latency. A valid bit travels
// with the data. On a bubble (act_valid_in low) the data registers hold their values and the
// valid bits drop.
//
// Weights are double-buffered:
//   - The shadow registers of a column form a shift chain (w_in -> shadow -> w_out). A column
//     of N PEs is loaded bottom-first by N shifts while the current tile is still computing.
//   - A commit wavefront (w_commit_in -> w_commit_out, one cycle per column) copies shadow into
//     active. This matches the activation skew, so each PE switches tiles exactly when the
//     first beat of the new tile reaches it.
//
// Ports:
//   clk, reset         clock; asynchronous active-high reset
//   act_in/act_out     activation from the left / registered to the right
//   act_valid_in/out   beat valid from the left / registered to the right
//   psum_in/psum_out   partial sum from above / registered result to below
//   psum_valid_out     psum_out holds a freshly computed value
//   w_in/w_out         shadow weight chain input / shadow register output
//   w_shift            column-wide shadow chain shift enable
//   w_commit_in/out    commit wavefront from the left / registered to the right
//   ovf                sticky overflow flag (result did not fit in ACC_WIDTH)
//   clear_ovf          synchronous clear of ovf; a same-cycle overflow takes priority

module ws_pe_dbuf #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned WEIGHT_WIDTH = 8,
  parameter int unsigned ACC_WIDTH    = 32,
  parameter bit          SIGNED       = 1'b1,
  parameter bit          SATURATE     = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_WIDTH-1:0]   act_in,
  input  logic                    act_valid_in,
  input  logic [ACC_WIDTH-1:0]    psum_in,
  output logic [DATA_WIDTH-1:0]   act_out,
  output logic                    act_valid_out,
  output logic [ACC_WIDTH-1:0]    psum_out,
  output logic                    psum_valid_out,
  input  logic [WEIGHT_WIDTH-1:0] w_in,
  input  logic                    w_shift,
  output logic [WEIGHT_WIDTH-1:0] w_out,
  input  logic                    w_commit_in,
  output logic                    w_commit_out,
  output logic                    ovf,
  input  logic                    clear_ovf
);

  // The true sum of an ACC_WIDTH partial sum and a product that fits in ACC_WIDTH always fits
  // in one extra bit. All arithmetic is therefore done at ACC_WIDTH+1 bits, and overflow is
  // read from the top two bits.
  localparam int unsigned SumWidth = ACC_WIDTH + 1;

  if (ACC_WIDTH < DATA_WIDTH + WEIGHT_WIDTH) begin : g_bad_acc_width
    $error("ws_pe_dbuf: ACC_WIDTH must be >= DATA_WIDTH + WEIGHT_WIDTH");
  end

  // ---------------------------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0]   act_q, act_d;
  logic                    act_valid_q, act_valid_d;
  logic [ACC_WIDTH-1:0]    psum_q, psum_d;
  logic                    psum_valid_q, psum_valid_d;
  logic [WEIGHT_WIDTH-1:0] shadow_q, shadow_d;
  logic [WEIGHT_WIDTH-1:0] active_q, active_d;
  logic                    commit_q, commit_d;
  logic                    ovf_q, ovf_d;

  // ---------------------------------------------------------------------------------------------
  // Datapath: extend, multiply, accumulate
  // ---------------------------------------------------------------------------------------------
  logic                 act_sgn, w_sgn, psum_sgn;
  logic [SumWidth-1:0]  act_ext, w_ext, psum_ext;
  logic [SumWidth-1:0]  prod, sum;
  logic                 sum_ovf;
  logic [ACC_WIDTH-1:0] sat_val;
  logic [ACC_WIDTH-1:0] mac_result;

  // In unsigned mode the extension bits are zero, so one datapath serves both modes.
  assign act_sgn  = SIGNED & act_in[DATA_WIDTH-1];
  assign w_sgn    = SIGNED & active_q[WEIGHT_WIDTH-1];
  assign psum_sgn = SIGNED & psum_in[ACC_WIDTH-1];

  assign act_ext  = {{(SumWidth - DATA_WIDTH){act_sgn}}, act_in};
  assign w_ext    = {{(SumWidth - WEIGHT_WIDTH){w_sgn}}, active_q};
  assign psum_ext = {psum_sgn, psum_in};

  // The low SumWidth bits of the product are exact because the true product fits in that width.
  assign prod = act_ext * w_ext;
  assign sum  = psum_ext + prod;

  always_comb begin
    sum_ovf = 1'b0;
    sat_val = '1;
    if (SIGNED) begin
      // The sign of the ACC_WIDTH+1 result says which rail was crossed.
      sum_ovf = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];
      sat_val = sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH - 1){1'b0}}}
                               : {1'b0, {(ACC_WIDTH - 1){1'b1}}};
    end else begin
      // Unsigned operands cannot go below zero, so only the upper rail is reachable.
      sum_ovf = sum[ACC_WIDTH];
      sat_val = '1;
    end
  end

  assign mac_result = (SATURATE && sum_ovf) ? sat_val : sum[ACC_WIDTH-1:0];

  // ---------------------------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    act_d        = act_q;
    act_valid_d  = act_valid_in;
    psum_d       = psum_q;
    psum_valid_d = act_valid_in;
    shadow_d     = shadow_q;
    active_d     = active_q;
    commit_d     = w_commit_in;
    ovf_d        = clear_ovf ? 1'b0 : ovf_q;

    // A bubble keeps the data registers unchanged; only the valid bits drop.
    if (act_valid_in) begin
      act_d  = act_in;
      psum_d = mac_result;
      if (sum_ovf) begin
        ovf_d = 1'b1;
      end
    end

    // The commit copies the shadow as it was before this edge. A shift in the same cycle
    // therefore loads the next tile's weight without disturbing the one being committed.
    if (w_commit_in) begin
      active_d = shadow_q;
    end
    if (w_shift) begin
      shadow_d = w_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      act_q        <= '0;
      act_valid_q  <= 1'b0;
      psum_q       <= '0;
      psum_valid_q <= 1'b0;
      shadow_q     <= '0;
      active_q     <= '0;
      commit_q     <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      act_q        <= act_d;
      act_valid_q  <= act_valid_d;
      psum_q       <= psum_d;
      psum_valid_q <= psum_valid_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      commit_q     <= commit_d;
      ovf_q        <= ovf_d;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Outputs: all come straight from registers
  // ---------------------------------------------------------------------------------------------
  assign act_out        = act_q;
  assign act_valid_out  = act_valid_q;
  assign psum_out       = psum_q;
  assign psum_valid_out = psum_valid_q;
  assign w_out          = shadow_q;
  assign w_commit_out   = commit_q;
  assign ovf            = ovf_q;

endmodule

// File: doc/ws_pe_dbuf.md
Name: ws_pe_dbuf

Overview:
Next-generation weight-stationary processing element for the systolic array. It generalises widths and signedness and widens the accumulator. It adds valid propagation so bubbles pass through the array, and double-buffers the weight: the next tile's weights shift into a shadow register while the current tile computes, then a commit wavefront makes them active.

Parameters:
DATA_WIDTH, 8, activation bit width
WEIGHT_WIDTH, 8, weight bit width
ACC_WIDTH, 32, partial-sum width; must be >= DATA_WIDTH+WEIGHT_WIDTH
SIGNED, 1, 1 = two's-complement operands and psum; 0 = unsigned
SATURATE, 0, 1 = clamp psum at ACC_WIDTH limits; 0 = wrap modulo 2^ACC_WIDTH

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
act_in  in  DATA_WIDTH  activation from left neighbour / feeder
act_valid_in  in  1  act_in and psum_in valid this cycle
psum_in  in  ACC_WIDTH  partial sum from PE above
act_out  out  DATA_WIDTH  registered activation to right neighbour
act_valid_out  out  1  registered valid to right neighbour
psum_out  out  ACC_WIDTH  registered partial sum to PE below
psum_valid_out  out  1  psum_out valid
w_in  in  WEIGHT_WIDTH  weight from PE above (shadow chain)
w_shift  in  1  column-wide shift enable for shadow chain
w_out  out  WEIGHT_WIDTH  current shadow register value, to PE below
w_commit_in  in  1  commit wavefront from left neighbour
w_commit_out  out  1  commit wavefront registered, to right neighbour
ovf  out  1  sticky saturation/overflow flag
clear_ovf  in  1  synchronous clear of ovf

Behaviour:
- Reset (async, any time incl. mid-tile): act_out=0, act_valid_out=0, psum_out=0, psum_valid_out=0, shadow=0, active weight=0, w_commit_out=0, ovf=0. Takes effect immediately; no partial state survives.
- MAC, 1-cycle latency. If act_valid_in=1 at edge: psum_out <= psum_in + act_in*w_active; act_out <= act_in; act_valid_out <= 1; psum_valid_out <= 1.
- If act_valid_in=0: act_out and psum_out hold their previous values; act_valid_out <= 0; psum_valid_out <= 0. Bubbles propagate; data does not change.
- Arithmetic: product is DATA_WIDTH+WEIGHT_WIDTH bits, sign- or zero-extended per SIGNED to ACC_WIDTH+1, then added to the extended psum_in.
- SATURATE=1: clamp to max/min of ACC_WIDTH, honouring SIGNED (unsigned min is 0).
- SATURATE=0: truncate to ACC_WIDTH (wrap).
- ovf: set on any valid cycle whose true sum does not fit in ACC_WIDTH, in both modes. Sticky. clear_ovf=1 clears it; if clear_ovf and a new overflow occur in the same cycle, set wins.
- Shadow chain: w_shift=1 -> shadow <= w_in. w_out is driven directly from the shadow register, so N shifts load an N-deep column bottom-first.
- Commit: w_commit_in=1 -> active <= shadow, and w_commit_out <= w_commit_in every cycle (1-cycle skew per column, matching activation skew).
- A MAC in the same cycle as a commit uses the OLD active weight; the new weight applies from the next edge.
- w_shift and w_commit_in in the same cycle: active takes the pre-shift shadow; shadow takes w_in.
- Weight loading and commit are independent of act_valid_in.
- No combinational path input->output except w_out, which comes from a register, not from w_in.

Test Plan:
- Reset mid-stream: valid data flowing, assert reset -> all outputs 0 the same cycle; after release, first valid beat with w_active=0 gives psum_out=psum_in.
- Basic MAC, SIGNED=1: shift w_in=-3, commit, then act_in=5, psum_in=100, valid -> next cycle psum_out=85, act_out=5, both valids 1.
- Bubble: valid=1 (act 7), then valid=0 with act_in=9 -> act_out stays 7, psum_out holds, valids drop to 0.
- Double buffer: active=2, shift 4 into shadow while streaming act=10 -> products use 2. Commit concurrent with act=10 -> that beat gives +20, next beat +40; w_commit_out pulses one cycle later.
- Saturation, SIGNED=1, ACC_WIDTH=16, SATURATE=1: psum_in=32760, act=127, w=127 -> psum_out=32767, ovf=1. Same with SATURATE=0 -> psum_out=(32760+16129) mod 2^16 as signed = -16647, ovf=1. clear_ovf -> ovf=0.
- Unsigned mode, SIGNED=0: act=255, w=255, psum_in=0 -> psum_out=65025. Shift+commit in the same cycle: active gets the old shadow value, shadow gets w_in.
